// File: rtl/regfile_dump_scanner.sv
// regfile_dump_scanner
//   Sweeps the regfile scan read port over addresses 0..NUM_REGS-1, samples
//   each value and buffers {addr,data,last} records in a small first-word-
//   fall-through FIFO that the VGA text renderer drains via valid/ready.
//   Scanning stalls while the FIFO is full, so no record is ever lost.
//   Optional feature macro: REGDUMP_CONTINUOUS_EN -- when defined the sweep
//   wraps from NUM_REGS-1 back to 0 forever instead of draining and idling.
module regfile_dump_scanner #(
  parameter int NUM_REGS   = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] scanAddr,
  input  logic [DATA_W-1:0] scanData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData,
  output logic              outLast,
  output logic              busy,
  output logic              done
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } scanStateT;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } recordT;

  scanStateT         state, stateNext;
  logic [ADDR_W-1:0] scanAddrNext;
  recordT            mem [FIFO_DEPTH];
  recordT            head;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [PTR_W:0]    count;
  logic              push, pop, fifoEmpty, fifoFull;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_COUNT);
  assign outValid  = !fifoEmpty;
  assign pop       = outValid && outReady;
  assign head      = mem[rdPtr];

  // Head fields read as zero when nothing is buffered, so reset values are clean.
  assign outAddr = outValid ? head.addr : '0;
  assign outData = outValid ? head.data : '0;
  assign outLast = outValid && head.last;
  assign busy    = (state == READ) || !fifoEmpty;

  // Next-state, next-address and push decision for the sweep FSM.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext    = state;
    scanAddrNext = scanAddr;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext    = READ;
          scanAddrNext = '0;
        end
      end
      READ: begin
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        if (!fifoFull || pop) begin
          push = 1'b1;
          if (scanAddr == LAST_ADDR) begin
`ifdef REGDUMP_CONTINUOUS_EN
            scanAddrNext = '0;
`else
            stateNext = DRAIN;
`endif
          end else begin
            scanAddrNext = scanAddr + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        // busy is already low here once empty, so a start is honoured directly.
        if (fifoEmpty) begin
          if (start) begin
            stateNext    = READ;
            scanAddrNext = '0;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state and registered scan address.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scanAddr <= '0;
    end else begin
      state    <= stateNext;
      scanAddr <= scanAddrNext;
    end
  end

  // Record storage; the sample is the regfile value in the push cycle.
  // NOTE: storage is not reset -- the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{addr: scanAddr, data: scanData, last: (scanAddr == LAST_ADDR)};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pass-complete pulse one cycle after the last record leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= pop && head.last;
  end

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// tb_regfile_dump_scanner
//   Directed bench: a regfile model drives scanData from scanAddr and a
//   consumer loop checks every visible head record against the expected
//   address sequence and regfile contents. Build with REGDUMP_CONTINUOUS_EN
//   to exercise the wrapping sweep instead of the single-pass cases.
module tb_regfile_dump_scanner;

  localparam int NUM_REGS = 64;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
`ifdef REGDUMP_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] scanAddr;
  logic [DATA_W-1:0] scanData;
  logic              outValid;
  logic              outReady;
  logic [ADDR_W-1:0] outAddr;
  logic [DATA_W-1:0] outData;
  logic              outLast;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign scanData = regs[scanAddr];

  regfile_dump_scanner #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .scanAddr(scanAddr), .scanData(scanData),
    .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .outData(outData), .outLast(outLast),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume nPops records. mode 0: outReady held 1; mode 2: outReady toggles.
  // Every visible head is checked against the expected next address, so a
  // stalled head that changes or a skipped/duplicated record is caught.
  task automatic consume(input int mode, input int nPops);
    int        pops = 0;
    int        cyc = 0;
    int        firstPop = -1;
    int        lastPop = -1;
    bit        expDone = 1'b0;
    bit        popNow;
    bit        lastNow;
    logic [ADDR_W-1:0] ea;
    while (pops < nPops && cyc < 3000) begin
      check("done", 32'(done), 32'(expDone));
      if (expDone) check("busy_at_done", 32'(busy), 32'(CONT));
      outReady = (mode == 2) ? cyc[0] : 1'b1;
      start    = (mode == 0 && cyc == 10);  // must be ignored mid-pass
      popNow   = 1'b0;
      lastNow  = 1'b0;
      if (outValid) begin
        ea = ADDR_W'(pops % NUM_REGS);
        check("out_addr", 32'(outAddr), 32'(ea));
        check("out_data", 32'(outData), 32'(regs[ea]));
        check("out_last", 32'(outLast), 32'(ea == ADDR_W'(NUM_REGS - 1)));
        if (outReady) begin
          popNow  = 1'b1;
          lastNow = (ea == ADDR_W'(NUM_REGS - 1));
          if (firstPop < 0) firstPop = cyc;
          lastPop = cyc;
          pops++;
        end
      end
      expDone = popNow && lastNow;
      tick();
      cyc++;
    end
    start = 1'b0;
    if (pops < nPops) check("timeout", 32'(pops), 32'(nPops));
    check("done_final", 32'(done), 32'(expDone));
    if (expDone) check("busy_final", 32'(busy), 32'(CONT));
    if (mode == 0) check("back_to_back", 32'(lastPop - firstPop), 32'(nPops - 1));
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = DATA_W'(16'h0011 + k);

    // 1: reset values, then quiet with no start.
    tick();
    tick();
    check("rst_scanAddr", 32'(scanAddr), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_outAddr",  32'(outAddr),  32'd0);
    check("rst_outData",  32'(outData),  32'd0);
    check("rst_outLast",  32'(outLast),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outValid", 32'(outValid), 32'd0);
    end

`ifdef REGDUMP_CONTINUOUS_EN
    // 6: wrapping sweep, done on every last pop, busy never falls.
    outReady = 1'b1;
    pulseStart();
    consume(0, 2 * NUM_REGS + 2);
    check("cont_busy", 32'(busy), 32'd1);
`else
    // 2: full-rate pass with outReady held high.
    outReady = 1'b1;
    pulseStart();
    consume(0, NUM_REGS);
    tick();

    // 3: stall until the FIFO fills, scan must hold at 8; then resume.
    outReady = 1'b0;
    pulseStart();
    regs[8] = 16'hBEEF;  // changed before address 8 is sampled
    for (int i = 0; i < 20; i++) tick();
    check("stall_scanAddr", 32'(scanAddr), 32'd8);
    check("stall_outValid", 32'(outValid), 32'd1);
    check("stall_outAddr",  32'(outAddr),  32'd0);
    check("stall_busy",     32'(busy),     32'd1);
    consume(0, NUM_REGS);
    regs[8] = 16'h0019;
    tick();

    // 4: outReady toggling every cycle.
    pulseStart();
    consume(2, NUM_REGS);
    tick();

    // 5: reset at record 30, no done, then a clean restart from address 0.
    outReady = 1'b1;
    pulseStart();
    consume(0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outValid", 32'(outValid), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_scanAddr", 32'(scanAddr), 32'd0);
    check("midrst_done",     32'(done),     32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_done",  32'(done),     32'd0);
      check("post_rst_valid", 32'(outValid), 32'd0);
    end
    pulseStart();
    consume(0, NUM_REGS);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
